// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array row feed path: feeder FSM states
// and the row-slice index helper used by the skew and valid-append stages.
package sa_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN
  } state_e;

  // MSB bit index of row `row_idx` in a packed vector with row 0 at the top.
  function automatic int row_msb(input int row_idx, input int rows, input int w_data);
    return w_data * (rows - row_idx) - 1;
  endfunction

endpackage

// File: rtl/sa_skew_line.sv
// One row's data+valid delay line, DEPTH register stages deep.
// A bubble (i_valid=0) keeps the entry data unchanged and only shifts a 0 valid.
module sa_skew_line #(
  parameter int DEPTH  = 1,
  parameter int W_DATA = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_valid,
  output logic [W_DATA-1:0] o_data,
  output logic              o_valid
);

  logic [W_DATA-1:0] data_q  [DEPTH];
  logic [W_DATA-1:0] data_d  [DEPTH];
  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];

  always_comb begin
    data_d[0]  = i_valid ? i_data : data_q[0];
    valid_d[0] = i_valid;
    for (int s = 1; s < DEPTH; s++) begin
      data_d[s]  = data_q[s-1];
      valid_d[s] = valid_q[s-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s]  <= '0;
        valid_q[s] <= 1'b0;
      end
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s]  <= data_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

  assign o_data  = data_q[DEPTH-1];
  assign o_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/in_sa_row_skew.sv
// Systolic-array row feeder: accepts one tile of row vectors and re-times it
// into a diagonal wavefront, row i delayed i cycles behind row 0.
module in_sa_row_skew
  import sa_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int W_DATA = 8,
  parameter int K_MAX  = 256,
  parameter int W_LEN  = $clog2(K_MAX + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [W_LEN-1:0]      i_len,
  input  logic [W_DATA*ROW-1:0] i_vec,
  input  logic                  i_vec_valid,
  output logic                  o_vec_ready,
  output logic [W_DATA*ROW-1:0] o_data,
  output logic [ROW-1:0]        o_data_valid,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int W_DRN = (ROW > 1) ? $clog2(ROW) : 1;

  state_e             state_q, state_d;
  logic [W_LEN-1:0]   len_q, len_d;
  logic [W_LEN-1:0]   beat_cnt_q, beat_cnt_d;
  logic [W_DRN-1:0]   drain_cnt_q, drain_cnt_d;
  logic               zero_done_q, zero_done_d;
  logic               push_valid;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    zero_done_d = 1'b0;
    push_valid  = 1'b0;
    o_vec_ready = (state_q == S_FEED);
    o_done      = zero_done_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            len_d      = i_len;
            beat_cnt_d = '0;
            state_d    = S_FEED;
          end
        end
      end
      S_FEED: begin
        if (i_vec_valid) begin
          push_valid = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Counter is W_LEN wide, so len = K_MAX is reached without wrapping.
          if (beat_cnt_d == len_q) begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == W_DRN'(ROW - 1)) begin
          o_done      = 1'b1;
          drain_cnt_d = '0;
          state_d     = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      zero_done_q <= zero_done_d;
    end
  end

  assign o_busy = (state_q != S_IDLE);

  for (genvar gi = 0; gi < ROW; gi++) begin : g_row
    localparam int MSB = row_msb(gi, ROW, W_DATA);
    sa_skew_line #(
      .DEPTH  (gi + 1),
      .W_DATA (W_DATA)
    ) u_line (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_vec[MSB -: W_DATA]),
      .i_valid (push_valid),
      .o_data  (o_data[MSB -: W_DATA]),
      .o_valid (o_data_valid[gi])
    );
  end

endmodule

// File: tb/tb_in_sa_row_skew.sv
// Self-checking bench for in_sa_row_skew: tile-level behavioural model with a
// per-cycle compare, plus hand-computed literal expectations per scenario.
module tb_in_sa_row_skew;

  localparam int ROW    = 8;
  localparam int W_DATA = 8;
  localparam int K_MAX  = 256;
  localparam int W_LEN  = 9;
  localparam int N_HIST = 4096;

  logic                  clk;
  logic                  rst_n;
  logic                  i_start;
  logic [W_LEN-1:0]      i_len;
  logic [W_DATA*ROW-1:0] i_vec;
  logic                  i_vec_valid;
  logic                  o_vec_ready;
  logic [W_DATA*ROW-1:0] o_data;
  logic [ROW-1:0]        o_data_valid;
  logic                  o_busy;
  logic                  o_done;

  in_sa_row_skew #(
    .ROW    (ROW),
    .W_DATA (W_DATA),
    .K_MAX  (K_MAX),
    .W_LEN  (W_LEN)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_vec        (i_vec),
    .i_vec_valid  (i_vec_valid),
    .o_vec_ready  (o_vec_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: mode 0 idle, 1 feeding, 2 draining.
  int   cyc = 0;
  int   mode = 0;
  int   beats_left = 0;
  int   drain_left = 0;
  bit   zdone = 1'b0;
  bit   hist_v [N_HIST];
  logic [W_DATA*ROW-1:0] hist_d [N_HIST];

  logic [ROW-1:0]        obs_v [N_HIST];
  logic [W_DATA*ROW-1:0] obs_d [N_HIST];
  int   last_done = -1;
  int   done_cnt  = 0;
  int   acc_cnt   = 0;
  bit   any_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W_DATA*ROW-1:0] vec_of(input int k, input int base);
    logic [W_DATA*ROW-1:0] v;
    v = '0;
    for (int r = 0; r < ROW; r++) v[W_DATA*(ROW-r)-1 -: W_DATA] = 8'((16*k + r + base) & 255);
    return v;
  endfunction

  function automatic logic [7:0] row_byte(input logic [W_DATA*ROW-1:0] v, input int r);
    return v[W_DATA*(ROW-r)-1 -: W_DATA];
  endfunction

  task automatic model_loop();
    bit hs;
    bit zd;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mode = 0; beats_left = 0; drain_left = 0; zdone = 1'b0;
        for (int i = 0; i < N_HIST; i++) hist_v[i] = 1'b0;
      end else begin
        hs = (mode == 1) && i_vec_valid;
        hist_v[cyc % N_HIST] = hs;
        hist_d[cyc % N_HIST] = i_vec;
        zd = 1'b0;
        case (mode)
          0: if (i_start) begin
               if (i_len == 0) zd = 1'b1;
               else begin mode = 1; beats_left = int'(i_len); end
             end
          1: if (hs) begin
               beats_left--;
               if (beats_left == 0) begin mode = 2; drain_left = ROW; end
             end
          default: begin
               drain_left--;
               if (drain_left == 0) mode = 0;
             end
        endcase
        zdone = zd;
        cyc++;
      end
    end
  endtask

  task automatic compare_loop();
    logic [ROW-1:0] ev;
    int idx;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        ev = '0;
        for (int r = 0; r < ROW; r++) begin
          idx = cyc - 1 - r;
          if (idx >= 0) ev[r] = hist_v[idx % N_HIST];
        end
        chk("ready", 64'(o_vec_ready), 64'(mode == 1));
        chk("busy", 64'(o_busy), 64'(mode != 0));
        chk("done", 64'(o_done), 64'(zdone || (mode == 2 && drain_left == 1)));
        chk("row_valid", 64'(o_data_valid), 64'(ev));
        for (int r = 0; r < ROW; r++) begin
          if (ev[r]) chk($sformatf("row%0d_data", r), 64'(row_byte(o_data, r)),
                         64'(row_byte(hist_d[(cyc - 1 - r) % N_HIST], r)));
        end
        obs_v[cyc % N_HIST] = o_data_valid;
        obs_d[cyc % N_HIST] = o_data;
        if (o_done) begin last_done = cyc; done_cnt++; end
        if (o_vec_ready && i_vec_valid) acc_cnt++;
        if (|o_data_valid) any_valid = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a tile in the current cycle and feed len beats; gap_n bubbles precede beat gap_at.
  task automatic feed_tile(input int len, input int gap_at, input int gap_n, input int base,
                           input bit pulse_in_feed, input bit hold_valid,
                           output int t0, output int t_last);
    t0 = -1;
    t_last = -1;
    i_start = 1'b1;
    i_len   = W_LEN'(len);
    tick();
    i_start = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        i_vec_valid = 1'b0;
        repeat (gap_n) tick();
      end
      i_vec = vec_of(k, base);
      i_vec_valid = 1'b1;
      if (pulse_in_feed && k == 1) begin i_start = 1'b1; i_len = 9'd7; end
      if (k == 0) t0 = cyc;
      t_last = cyc;
      tick();
      i_start = 1'b0;
    end
    i_vec_valid = hold_valid;
  endtask

  task automatic drain(input bit pulse_in_drain);
    for (int j = 0; j < ROW; j++) begin
      if (pulse_in_drain && j == 1) begin i_start = 1'b1; i_len = 9'd6; end
      tick();
      i_start = 1'b0;
    end
  endtask

  initial begin
    int t0, tl, t0b, tlb, d0, a0;
    logic [6:0] pat;
    rst_n = 1'b0; i_start = 1'b0; i_len = '0; i_vec = '0; i_vec_valid = 1'b0;
    fork
      model_loop();
      compare_loop();
    join_none
    #1;
    chk("rst_data", o_data, 64'h0);
    chk("rst_valid", 64'(o_data_valid), 64'h0);
    chk("rst_ready", 64'(o_vec_ready), 64'h0);
    chk("rst_busy", 64'(o_busy), 64'h0);
    chk("rst_done", 64'(o_done), 64'h0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick(); tick();

    // Basic tile: len 4, valid held high, byte = 16k+r.
    d0 = done_cnt;
    feed_tile(4, -1, 0, 0, 1'b0, 1'b0, t0, tl);
    drain(1'b0);
    tick();
    chk("basic_v_t1", 64'(obs_v[(t0+1) % N_HIST]), 64'h01);
    chk("basic_r0_t1", 64'(row_byte(obs_d[(t0+1) % N_HIST], 0)), 64'h00);
    chk("basic_v_t4", 64'(obs_v[(t0+4) % N_HIST]), 64'h0F);
    chk("basic_r0_t4", 64'(row_byte(obs_d[(t0+4) % N_HIST], 0)), 64'h30);
    chk("basic_r3_t4", 64'(row_byte(obs_d[(t0+4) % N_HIST], 3)), 64'h03);
    chk("basic_v_t8", 64'(obs_v[(t0+8) % N_HIST]), 64'hF0);
    chk("basic_r7_t8", 64'(row_byte(obs_d[(t0+8) % N_HIST], 7)), 64'h07);
    chk("basic_r4_t8", 64'(row_byte(obs_d[(t0+8) % N_HIST], 4)), 64'h34);
    chk("basic_v_t12", 64'(obs_v[(t0+12) % N_HIST]), 64'h00);
    chk("basic_done_cyc", 64'(last_done - t0), 64'd11);
    chk("basic_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Bubbles: len 5, two idle cycles after beat 1.
    feed_tile(5, 2, 2, 64, 1'b0, 1'b0, t0, tl);
    drain(1'b0);
    tick();
    pat = 7'b1100111;
    chk("bub_last_hs", 64'(tl - t0), 64'd6);
    for (int j = 0; j < 7; j++)
      chk($sformatf("bub_r2_v%0d", j), 64'(obs_v[(t0+3+j) % N_HIST][2]), 64'(pat[6-j]));
    chk("bub_r2_beat2", 64'(row_byte(obs_d[(t0+7) % N_HIST], 2)), 64'h62);
    chk("bub_done_cyc", 64'(last_done - t0), 64'd14);

    // Zero length.
    i_start = 1'b1; i_len = '0;
    tick();
    i_start = 1'b0;
    @(negedge clk);
    chk("zero_done", 64'(o_done), 64'd1);
    chk("zero_busy", 64'(o_busy), 64'd0);
    tick();
    @(negedge clk);
    chk("zero_done_off", 64'(o_done), 64'd0);
    tick();

    // Start pulses in FEED and DRAIN ignored; restart in first IDLE cycle.
    feed_tile(4, -1, 0, 128, 1'b1, 1'b0, t0, tl);
    drain(1'b1);
    feed_tile(4, -1, 0, 160, 1'b0, 1'b0, t0b, tlb);
    drain(1'b0);
    tick();
    chk("start_first_len", 64'(tl - t0), 64'd3);
    chk("start_b2b_gap", 64'(t0b - tl), 64'(ROW + 2));
    chk("start_done_cyc", 64'(last_done - tlb), 64'(ROW));

    // Reset mid-DRAIN with valids in flight.
    feed_tile(3, -1, 0, 16, 1'b0, 1'b0, t0, tl);
    tick();
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", o_data, 64'h0);
    chk("mid_rst_valid", 64'(o_data_valid), 64'h0);
    chk("mid_rst_ready", 64'(o_vec_ready), 64'h0);
    chk("mid_rst_busy", 64'(o_busy), 64'h0);
    chk("mid_rst_done", 64'(o_done), 64'h0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (12) tick();
    chk("post_rst_no_valid", 64'(any_valid), 64'd0);

    // Length boundary: K_MAX beats, valid kept high afterwards.
    a0 = acc_cnt;
    feed_tile(K_MAX, -1, 0, 3, 1'b0, 1'b1, t0, tl);
    @(negedge clk);
    chk("kmax_ready_drop", 64'(o_vec_ready), 64'd0);
    i_vec_valid = 1'b0;
    drain(1'b0);
    tick();
    chk("kmax_accepted", 64'(acc_cnt - a0), 64'(K_MAX));
    chk("kmax_done_cyc", 64'(last_done - tl), 64'(ROW));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
